// File: rtl/fir_resp_pkg.sv
// Shared register offsets, ap_ctrl bit positions and FSM encodings for the FIR responder.
package fir_resp_pkg;

  localparam logic [7:0] ADDR_AP_CTRL = 8'h00;
  localparam logic [7:0] ADDR_LEN     = 8'h10;
  localparam logic [7:0] ADDR_COEF    = 8'h40;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;
  localparam int AP_ERR_BIT   = 3;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_RUN   = 2'd1,
    ENG_DRAIN = 2'd2
  } eng_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head visible while !empty_o, zero-latency pop.
// Push is dropped when full and pop when empty, so a full FIFO pops before it can accept again.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/axi_fir_responder.sv
// AXI-Lite ap_ctrl/length/coef slave plus ss->sm scaler (Y = X*coef) standing in for the FIR endpoint.
// rvalid 2 cycles after arvalid; Y buffered in FIFO, ss stalls when full. SS_TLAST_CHECK_EN adds ap_ctrl[3] err.
module axi_fir_responder
  import fir_resp_pkg::*;
#(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam logic [pDATA_WIDTH-1:0] ONE = 1;

  logic                   wr_rdy_q, wr_rdy_d, wr_fire, start_fire;
  rd_state_e              r_state_q;
  logic                   arready_q, rvalid_q, rd_clr;
  logic [pDATA_WIDTH-1:0] rdata_q, rd_val, ap_ctrl_val;
  logic [7:0]             rd_addr_q;
  eng_state_e             eng_q;
  logic                   ap_start_q, ap_done_q, ap_idle_q, ap_err;
  logic [pDATA_WIDTH-1:0] len_q, coef_q, in_cnt_q, out_cnt_q, last_idx, y_dat, head_dat;
  logic                   fifo_full, fifo_empty, ss_fire, sm_fire, last_fire;
  logic                   unused_bits;

  assign unused_bits = ^{awaddr[pADDR_WIDTH-1:8], araddr[pADDR_WIDTH-1:8], ss_tlast};

  // Bridge holds valids through the ack cycle, so suppress a second pulse right after the first.
  assign wr_rdy_d   = awvalid && wvalid && !wr_rdy_q;
  assign wr_fire    = wr_rdy_q && awvalid && wvalid;
  assign start_fire = wr_fire && ap_idle_q && (awaddr[7:0] == ADDR_AP_CTRL) && wdata[0];
  assign awready    = wr_rdy_q;
  assign wready     = wr_rdy_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wr_rdy_q <= 1'b0;
    else          wr_rdy_q <= wr_rdy_d;
  end

  always_comb begin
    ap_ctrl_val               = '0;
    ap_ctrl_val[AP_START_BIT] = ap_start_q;
    ap_ctrl_val[AP_DONE_BIT]  = ap_done_q;
    ap_ctrl_val[AP_IDLE_BIT]  = ap_idle_q;
    ap_ctrl_val[AP_ERR_BIT]   = ap_err;
  end

  always_comb begin
    rd_val = '0;
    case (araddr[7:0])
      ADDR_AP_CTRL: rd_val = ap_ctrl_val;
      ADDR_LEN:     rd_val = len_q;
      ADDR_COEF:    rd_val = coef_q;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (arvalid) begin
          r_state_q <= R_ADDR;
          arready_q <= 1'b1;
        end
        R_ADDR: begin
          r_state_q <= R_DATA;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_val;
          rd_addr_q <= araddr[7:0];
        end
        R_DATA: if (rready) begin
          r_state_q <= R_IDLE;
          rvalid_q  <= 1'b0;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rd_clr  = (r_state_q == R_DATA) && rready && (rd_addr_q == ADDR_AP_CTRL);

  assign last_idx  = len_q - ONE;
  assign y_dat     = ss_tdata * coef_q;
  assign ss_tready = (eng_q == ENG_RUN) && !fifo_full && (in_cnt_q < len_q);
  assign ss_fire   = ss_tvalid && ss_tready;
  assign sm_tvalid = (eng_q != ENG_IDLE) && !fifo_empty;
  assign sm_tdata  = sm_tvalid ? head_dat : '0;
  assign sm_tlast  = sm_tvalid && (out_cnt_q == last_idx);
  assign sm_fire   = sm_tvalid && sm_tready;
  assign last_fire = sm_fire && sm_tlast;

  sync_fifo #(.DEPTH(pFIFO_DEPTH), .WIDTH(pDATA_WIDTH)) u_fifo (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .push_i     (ss_fire),
    .push_dat_i (y_dat),
    .pop_i      (sm_fire),
    .pop_dat_o  (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      eng_q      <= ENG_IDLE;
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      len_q      <= '0;
      coef_q     <= ONE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
    end else begin
      if (rd_clr) ap_done_q <= 1'b0;
      if (ss_fire) in_cnt_q <= in_cnt_q + ONE;
      if (sm_fire) out_cnt_q <= out_cnt_q + ONE;
      if (wr_fire && ap_idle_q) begin
        case (awaddr[7:0])
          ADDR_LEN:  len_q  <= wdata;
          ADDR_COEF: coef_q <= wdata;
          default:   ;
        endcase
      end
      if (start_fire) begin
        ap_start_q <= 1'b1;
        ap_idle_q  <= 1'b0;
        ap_done_q  <= 1'b0;
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
      end
      case (eng_q)
        ENG_IDLE: if (ap_start_q) begin
          if (len_q == '0) begin
            ap_start_q <= 1'b0;
            ap_done_q  <= 1'b1;
            ap_idle_q  <= 1'b1;
          end else begin
            eng_q <= ENG_RUN;
          end
        end
        ENG_RUN: begin
          ap_start_q <= 1'b0;
          // The final Y can leave in the same cycle the input count completes.
          if (in_cnt_q == len_q) begin
            if (last_fire) begin
              eng_q     <= ENG_IDLE;
              ap_done_q <= 1'b1;
              ap_idle_q <= 1'b1;
            end else begin
              eng_q <= ENG_DRAIN;
            end
          end
        end
        ENG_DRAIN: if (last_fire) begin
          eng_q     <= ENG_IDLE;
          ap_done_q <= 1'b1;
          ap_idle_q <= 1'b1;
        end
        default: eng_q <= ENG_IDLE;
      endcase
    end
  end

`ifdef SS_TLAST_CHECK_EN
  logic err_q;
  logic in_last;
  assign in_last = (in_cnt_q == last_idx);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                             err_q <= 1'b0;
    else if (start_fire)                      err_q <= 1'b0;
    else if (ss_fire && (ss_tlast != in_last)) err_q <= 1'b1;
  end
  assign ap_err = err_q;
`else
  assign ap_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_fir_responder.sv
// Directed bench for axi_fir_responder: bridge-style AXI-Lite accesses and ss/sm streaming with hand-derived Y values.
module tb_axi_fir_responder;

  localparam logic [31:0] BASE = 32'h3100_0000;

  logic        wb_clk_i, wb_rst_i;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
  logic [31:0] ss_tdata, sm_tdata;

  int n_vec = 0;
  int n_err = 0;

  axi_fir_responder #(.pADDR_WIDTH(32), .pDATA_WIDTH(32), .pFIFO_DEPTH(8)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .awvalid  (awvalid),  .awready  (awready),  .awaddr (awaddr),
    .wvalid   (wvalid),   .wready   (wready),   .wdata  (wdata),
    .arvalid  (arvalid),  .arready  (arready),  .araddr (araddr),
    .rvalid   (rvalid),   .rready   (rready),   .rdata  (rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data);
    int lat = 0;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
    do begin cyc(); lat++; end while (!awready && lat < 20);
    chk("wr_latency", lat, 1);
    chk("wr_ready_pair", {awready, wready}, 2'b11);
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_pulse_end", {awready, wready}, 2'b00);
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data);
    int lat = 0;
    arvalid = 1'b1; rready = 1'b1; araddr = addr;
    do begin
      cyc(); lat++;
      if (lat == 1) chk("arready_pulse", arready, 1);
    end while (!rvalid && lat < 20);
    chk("rd_latency", lat, 2);
    data = rdata;
    cyc();
    arvalid = 1'b0; rready = 1'b0;
    chk("rvalid_end", rvalid, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_rd(addr, d);
    chk(tag, d, exp);
  endtask

  // Streams X = base+k; expects Y = X*coef in order, tlast only on the n-th.
  task automatic stream(input int n, input logic [31:0] base, input logic [31:0] coef,
                        input int stall, input int exp_fill);
    int i = 0;
    int j = 0;
    int c = 0;
    logic [31:0] x, yexp;
    while (j < n && c < 400) begin
      cyc();
      ss_tvalid = (i < n); ss_tdata = base + i; sm_tready = (c >= stall);
      #1;
      if (stall > 0 && c == stall - 1) begin
        chk("fill_count", i, exp_fill);
        chk("ss_tready_full", ss_tready, 0);
      end
      if (ss_tvalid && ss_tready) i++;
      if (sm_tvalid && sm_tready) begin
        x = base + j;
        yexp = x * coef;
        chk("y_data", sm_tdata, yexp);
        chk("y_tlast", sm_tlast, (j == n - 1));
        j++;
      end
      c++;
    end
    chk("y_beats", j, n);
    chk("x_pushed", i, n);
    cyc();
    ss_tvalid = 1'b0; sm_tready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    wb_rst_i = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; araddr = 0;
    ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0; sm_tready = 0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    cyc();

    // Reset state
    chk("reset_ctrl_outs", {awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 7'b0);
    chk("reset_rdata", rdata, 0);
    chk("reset_sm_tdata", sm_tdata, 0);
    rd_chk("reset_ap_ctrl", BASE + 32'h00, 32'h4);
    rd_chk("reset_coef", BASE + 32'h40, 32'h1);
    rd_chk("reset_len", BASE + 32'h10, 32'h0);

    // Write/readback and unmapped offset
    axi_wr(BASE + 32'h10, 32'd5);
    rd_chk("len_readback", BASE + 32'h10, 32'd5);
    axi_wr(BASE + 32'h20, 32'hDEAD_BEEF);
    rd_chk("unmapped_read", BASE + 32'h20, 32'h0);

    // Basic run: coef 3, len 4
    axi_wr(BASE + 32'h40, 32'd3);
    axi_wr(BASE + 32'h10, 32'd4);
    axi_wr(BASE + 32'h00, 32'h1);
    stream(4, 32'd1, 32'd3, 0, 0);
    rd_chk("done_ap_ctrl", BASE + 32'h00, 32'h6);
    rd_chk("done_cleared", BASE + 32'h00, 32'h4);

    // Backpressure: len 10, sink stalled until FIFO fills
    axi_wr(BASE + 32'h10, 32'd10);
    axi_wr(BASE + 32'h00, 32'h1);
    stream(10, 32'd100, 32'd3, 20, 8);
    rd_chk("bp_done", BASE + 32'h00, 32'h6);

    // Busy writes ignored; coef wraps the product
    axi_wr(BASE + 32'h40, 32'h8000_0001);
    axi_wr(BASE + 32'h10, 32'd6);
    axi_wr(BASE + 32'h00, 32'h1);
    axi_wr(BASE + 32'h00, 32'h1);
    axi_wr(BASE + 32'h40, 32'd5);
    axi_wr(BASE + 32'h10, 32'd2);
    rd_chk("busy_ap_ctrl", BASE + 32'h00, 32'h0);
    rd_chk("busy_coef_kept", BASE + 32'h40, 32'h8000_0001);
    stream(6, 32'd3, 32'h8000_0001, 0, 0);
    rd_chk("busy_run_done", BASE + 32'h00, 32'h6);

    // Zero length start
    axi_wr(BASE + 32'h10, 32'd0);
    axi_wr(BASE + 32'h00, 32'h1);
    ss_tvalid = 1'b1; ss_tdata = 32'd9;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("len0_ss_tready", ss_tready, 0);
    end
    ss_tvalid = 1'b0;
    rd_chk("len0_done", BASE + 32'h00, 32'h6);

    // Reset mid-stream
    axi_wr(BASE + 32'h10, 32'd6);
    axi_wr(BASE + 32'h00, 32'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      ss_tvalid = 1'b1; ss_tdata = 32'd77 + k; sm_tready = 1'b0;
    end
    cyc();
    chk("pre_reset_sm_tvalid", sm_tvalid, 1);
    wb_rst_i = 1'b1;
    #1;
    chk("midrst_ctrl_outs", {awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 7'b0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_sm_tdata", sm_tdata, 0);
    ss_tvalid = 1'b0;
    cyc();
    wb_rst_i = 1'b0;
    cyc();
    rd_chk("post_rst_ap_ctrl", BASE + 32'h00, 32'h4);
    rd_chk("post_rst_coef", BASE + 32'h40, 32'h1);
    rd_chk("post_rst_len", BASE + 32'h10, 32'h0);
    axi_wr(BASE + 32'h10, 32'd3);
    axi_wr(BASE + 32'h00, 32'h1);
    stream(3, 32'd40, 32'd1, 0, 0);
    rd_chk("post_rst_done", BASE + 32'h00, 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
